// File: rtl/icache_direct_mapped.sv
// Direct-mapped read-only instruction cache: 8 lines x 4 words, combinational hit, line fill on miss.
// Optional hit/miss counters are enabled by defining ICACHE_STATS_EN.
module icache_direct_mapped #(
  parameter int NUM_LINES      = 8,
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_BITS      = 10
) (
  input  logic                                        CLK,
  input  logic                                        RESET,
  input  logic [31:0]                                 PC,
  output logic [31:0]                                 INSTRUCTION,
  output logic                                        BUSYWAIT,
  output logic                                        MEM_READ,
  output logic [ADDR_BITS-$clog2(WORDS_PER_LINE)-3:0] MEM_ADDRESS,
  input  logic [32*WORDS_PER_LINE-1:0]                MEM_READDATA,
  input  logic                                        MEM_BUSYWAIT
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0]                                 HIT_COUNT,
  output logic [15:0]                                 MISS_COUNT
`endif
);

  localparam int OFF_W  = $clog2(WORDS_PER_LINE);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int BLK_W  = ADDR_BITS - OFF_W - 2;
  localparam int TAG_W  = BLK_W - IDX_W;
  localparam int LINE_W = 32 * WORDS_PER_LINE;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_FILL} state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [NUM_LINES-1:0]   r_valid;
  logic [TAG_W-1:0]       r_tag  [NUM_LINES];
  logic [LINE_W-1:0]      r_data [NUM_LINES];
  logic [BLK_W-1:0]       r_miss_block;
  logic                   r_fetch_first;

  logic [TAG_W-1:0]       w_tag;
  logic [IDX_W-1:0]       w_index;
  logic [OFF_W-1:0]       w_offset;
  logic [BLK_W-1:0]       w_block;
  logic [OFF_W+4:0]       w_word_sel;
  logic                   w_hit;
  logic                   w_capture;
  logic                   w_unused;

  assign w_tag      = PC[ADDR_BITS-1 -: TAG_W];
  assign w_index    = PC[OFF_W+2 +: IDX_W];
  assign w_offset   = PC[2 +: OFF_W];
  assign w_block    = PC[ADDR_BITS-1:OFF_W+2];
  assign w_word_sel = {w_offset, 5'd0};
  assign w_unused   = ^{PC[31:ADDR_BITS], PC[1:0]};

  assign w_hit     = r_valid[w_index] && (r_tag[w_index] == w_tag);
  // The first FETCH cycle is skipped: memory has not yet seen MEM_READ, so its busy flag is stale.
  assign w_capture = (r_state == S_FETCH) && !r_fetch_first && !MEM_BUSYWAIT;

  assign INSTRUCTION = r_data[w_index][w_word_sel +: 32];
  assign MEM_ADDRESS = r_miss_block;

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (!w_hit) w_next = S_FETCH;
      S_FETCH: if (w_capture) w_next = S_FILL;
      S_FILL:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    BUSYWAIT = 1'b1;
    MEM_READ = 1'b0;
    case (r_state)
      S_IDLE:  BUSYWAIT = !w_hit;
      S_FETCH: MEM_READ = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_valid       <= '0;
      r_miss_block  <= '0;
      r_fetch_first <= 1'b0;
      for (int i = 0; i < NUM_LINES; i++) begin
        r_tag[i]  <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (r_state == S_IDLE && !w_hit) begin
        r_miss_block  <= w_block;
        r_fetch_first <= 1'b1;
      end
      if (r_state == S_FETCH) r_fetch_first <= 1'b0;
      if (w_capture) begin
        r_data[r_miss_block[IDX_W-1:0]]  <= MEM_READDATA;
        r_tag[r_miss_block[IDX_W-1:0]]   <= r_miss_block[BLK_W-1 -: TAG_W];
        r_valid[r_miss_block[IDX_W-1:0]] <= 1'b1;
      end
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] r_prev_pc;
  logic        r_after_fill;
  logic [15:0] r_hit_cnt;
  logic [15:0] r_miss_cnt;
  logic        w_hit_evt;
  logic        w_miss_evt;

  // A hit is counted once per new PC, plus the retried fetch that follows a fill.
  assign w_hit_evt  = (r_state == S_IDLE) && w_hit && ((PC != r_prev_pc) || r_after_fill);
  assign w_miss_evt = (r_state == S_IDLE) && !w_hit;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_prev_pc    <= '0;
      r_after_fill <= 1'b0;
      r_hit_cnt    <= '0;
      r_miss_cnt   <= '0;
    end else begin
      r_prev_pc    <= PC;
      r_after_fill <= (r_state == S_FILL);
      if (w_hit_evt && r_hit_cnt != 16'hFFFF)   r_hit_cnt  <= r_hit_cnt + 16'd1;
      if (w_miss_evt && r_miss_cnt != 16'hFFFF) r_miss_cnt <= r_miss_cnt + 16'd1;
    end
  end

  assign HIT_COUNT  = r_hit_cnt;
  assign MISS_COUNT = r_miss_cnt;
`endif

endmodule
